regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Write-back buffer sitting directly upstream of the 16x16-bit register file (regFile16b8).
- Accepts (address, data) write requests from the execute/memory stages through a valid/ready handshake and holds them in a small FIFO.
- Drains one entry per cycle into the register file's single write port (Write, WriteAddr, DataIn) whenever that port is granted.
- Also resolves read-after-write hazards on the two register-file read ports for entries still pending in the queue.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- AW, 4, register address width; 16 registers.
- DW, 16, data width.

Ports:
- CLK  in  1  rising-edge clock.
- Reset_n  in  1  synchronous, active-low reset.
- Flush  in  1  synchronous clear of all pending entries.
- InValid  in  1  write request present.
- InAddr  in  AW  destination register.
- InData  in  DW  value to write.
- InReady  out  1  queue can accept a request this cycle.
- DrainEn  in  1  register-file write port granted this cycle.
- Write  out  1  register-file write enable.
- WriteAddr  out  AW  register-file write address (queue head).
- DataIn  out  DW  register-file write data (queue head).
- ReadAddrA  in  AW  register-file read address A (snooped).
- ReadAddrB  in  AW  register-file read address B (snooped).
- ReadDataA  in  DW  register-file read data A.
- ReadDataB  in  DW  register-file read data B.
- OperandA  out  DW  hazard-resolved operand A.
- OperandB  out  DW  hazard-resolved operand B.
- HazardA  out  1  read A matches a pending entry that is not forwarded.
- HazardB  out  1  read B matches a pending entry that is not forwarded.
- Count  out  log2(DEPTH)+1  number of pending entries.

Behaviour:
- Reset (Reset_n=0 at a rising edge of CLK) clears the read and write pointers, Count and all valid bits. It takes priority over every other input.
  - After reset: InReady=1, Write=0, WriteAddr=0, DataIn=0, HazardA=HazardB=0.
- InReady = (Count != DEPTH), purely combinational.
  - When full, InReady stays 0 even if a drain occurs in the same cycle. There is no full-pass-through.
- Enqueue happens on an edge where InValid && InReady. The entry is written at the tail and the tail pointer increments, wrapping modulo DEPTH.
- Head outputs:
  - Write = (Count != 0) && DrainEn.
  - WriteAddr and DataIn equal the head entry when Count != 0, otherwise 0.
- Dequeue happens on the same edge the register file latches the write (Write=1). The head pointer increments with wrap.
- Simultaneous enqueue and dequeue leaves Count unchanged and both pointers advance.
- Latency: a request accepted at edge k reaches the head after edge k. Its earliest register-file write is edge k+1.
- Ordering is strict FIFO.
  - Multiple pending entries to the same register are all written, in order, so the last one wins.
- Flush=1 at an edge empties the queue: pointers reset, Count=0.
  - An enqueue in the same cycle is dropped.
  - A drain in the same cycle is still presented (Write follows the rule above), but the head write still occurs to the register file that cycle.
- Hazard detection is combinational over the valid entries. A match means entry.addr == ReadAddrX.
  - The newest matching entry (closest to the tail) is selected.
  - The entry being dequeued this cycle still counts as pending. The register-file read is not write-through.
- Count saturation: never exceeds DEPTH and never goes below 0. Dequeue is impossible when empty because Write=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - OperandX = data of the newest pending entry matching ReadAddrX, else ReadDataX.
  - HazardX is tied to 0.
- Undefined:
  - OperandX = ReadDataX unconditionally.
  - HazardX = 1 whenever any pending entry matches ReadAddrX, so control must stall until the entry drains.
  - The comparator logic is kept; only the data mux is removed.

Test Plan:
- Reset: hold Reset_n=0 for 2 edges with InValid=1 -> Count=0, InReady=1, Write=0, WriteAddr=0, DataIn=0.
- Fill/full: DrainEn=0; enqueue addr 1..4 with data 0x0011..0x0014 -> Count=4, InReady=0. A 5th request (addr 5) is not accepted. Then DrainEn=1 for 4 cycles -> Write=1 with (1,0x0011),(2,0x0012),(3,0x0013),(4,0x0014) in order, then Count=0, Write=0.
- Simultaneous: Count=2, InValid=1 and DrainEn=1 on one edge -> Count stays 2, head advances, new entry lands at the tail, and pointer wrap past DEPTH-1 is exercised.
- Same-register ordering: enqueue (7,0xAAAA) then (7,0xBBBB), ReadAddrA=7, ReadDataA=0x0000 ->
  - with WB_BYPASS_EN: OperandA=0xBBBB, HazardA=0;
  - without: OperandA=0x0000, HazardA=1 until both entries drain; the register file ends with r7=0xBBBB.
- Flush: Count=3, Flush=1 with InValid=1 on the same edge -> Count=0 next cycle, the input is dropped, HazardA/B=0.
- Reset mid-operation: Count=2, DrainEn=1, Reset_n=0 -> Count=0 after the edge. No further Write pulses occur until a new enqueue.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Write-back FIFO in front of the 16x16 register file, with read-after-write snooping.
// Define WB_BYPASS_EN to forward pending data to the operands instead of raising HazardA/B.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  input  logic                   Flush,
  input  logic                   InValid,
  input  logic [AW-1:0]          InAddr,
  input  logic [DW-1:0]          InData,
  output logic                   InReady,
  input  logic                   DrainEn,
  output logic                   Write,
  output logic [AW-1:0]          WriteAddr,
  output logic [DW-1:0]          DataIn,
  input  logic [AW-1:0]          ReadAddrA,
  input  logic [AW-1:0]          ReadAddrB,
  input  logic [DW-1:0]          ReadDataA,
  input  logic [DW-1:0]          ReadDataB,
  output logic [DW-1:0]          OperandA,
  output logic [DW-1:0]          OperandB,
  output logic                   HazardA,
  output logic                   HazardB,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];

  logic enq;
  logic match_a, match_b;
`ifdef WB_BYPASS_EN
  logic [DW-1:0] sel_a, sel_b;
`endif

  assign InReady   = (count_q != CW'(DEPTH));
  assign Write     = (count_q != '0) && DrainEn;
  assign WriteAddr = (count_q != '0) ? addr_q[rd_ptr_q] : '0;
  assign DataIn    = (count_q != '0) ? data_q[rd_ptr_q] : '0;
  assign Count     = count_q;

  always_comb begin
    enq      = InValid && InReady && !Flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = '0;
    end else begin
      if (enq) begin
        addr_d[wr_ptr_q]  = InAddr;
        data_d[wr_ptr_q]  = InData;
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (Write) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(enq) - CW'(Write);
    end
  end

  // Walk from head to tail so the last hit is the newest pending entry.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    match_a = 1'b0;
    match_b = 1'b0;
`ifdef WB_BYPASS_EN
    sel_a   = '0;
    sel_b   = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == ReadAddrA)) begin
        match_a = 1'b1;
`ifdef WB_BYPASS_EN
        sel_a   = data_q[idx];
`endif
      end
      if (valid_q[idx] && (addr_q[idx] == ReadAddrB)) begin
        match_b = 1'b1;
`ifdef WB_BYPASS_EN
        sel_b   = data_q[idx];
`endif
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign OperandA = match_a ? sel_a : ReadDataA;
  assign OperandB = match_b ? sel_b : ReadDataB;
  assign HazardA  = 1'b0;
  assign HazardB  = 1'b0;
`else
  assign OperandA = ReadDataA;
  assign OperandB = ReadDataB;
  assign HazardA  = match_a;
  assign HazardB  = match_b;
`endif

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset; the valid bits qualify every use.
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_regfile_wb_queue;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0, Flush = 1'b0, InValid = 1'b0, DrainEn = 1'b0;
  logic [3:0]  InAddr = '0, ReadAddrA = '0, ReadAddrB = '0;
  logic [15:0] InData = '0, ReadDataA = '0, ReadDataB = '0;
  logic        InReady, Write, HazardA, HazardB;
  logic [3:0]  WriteAddr;
  logic [15:0] DataIn, OperandA, OperandB;
  logic [2:0]  Count;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_queue #(.DEPTH(4), .AW(4), .DW(16)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Flush(Flush),
    .InValid(InValid), .InAddr(InAddr), .InData(InData), .InReady(InReady),
    .DrainEn(DrainEn), .Write(Write), .WriteAddr(WriteAddr), .DataIn(DataIn),
    .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB), .ReadDataA(ReadDataA), .ReadDataB(ReadDataB),
    .OperandA(OperandA), .OperandB(OperandB), .HazardA(HazardA), .HazardB(HazardB),
    .Count(Count)
  );

  always #5 CLK = ~CLK;

  // Register file as written by the DUT's write port.
  logic [15:0] rf_dut [16];
  int          wr_pulses = 0;
  always @(posedge CLK) begin
    if (Write === 1'b1) begin
      rf_dut[WriteAddr] <= DataIn;
      wr_pulses <= wr_pulses + 1;
    end
  end

  // Reference model: pending writes as an ordered list.
  typedef struct packed { logic [3:0] a; logic [15:0] d; } ent_t;
  ent_t q[$];

  function automatic logic any_match(input logic [3:0] addr);
    logic m = 1'b0;
    foreach (q[i]) if (q[i].a == addr) m = 1'b1;
    return m;
  endfunction

  function automatic logic [15:0] newest(input logic [3:0] addr, input logic [15:0] rd);
    logic [15:0] r = rd;
    foreach (q[i]) if (q[i].a == addr) r = q[i].d;
    return r;
  endfunction

  task automatic model_update();
    bit can_enq;
    if (!Reset_n || Flush) q.delete();
    else begin
      can_enq = (q.size() < 4);
      if (DrainEn && q.size() > 0) void'(q.pop_front());
      if (InValid && can_enq) q.push_back('{a: InAddr, d: InData});
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; InValid = 1'b1; DrainEn = 1'b1; InAddr = 4'd3; InData = 16'h1234;
    tick(); tick();
    InValid = 1'b0;
    #1;
    n_cmp++; if (Count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", Count); end
    n_cmp++; if (InReady !== 1'b1) begin n_err++; $display("FAIL reset_inready: got %b want 1", InReady); end
    n_cmp++; if (Write !== 1'b0) begin n_err++; $display("FAIL reset_write: got %b want 0", Write); end
    n_cmp++; if ({WriteAddr, DataIn} !== 20'h0) begin n_err++; $display("FAIL reset_head: got %h/%h want 0/0", WriteAddr, DataIn); end
    n_cmp++; if ({HazardA, HazardB} !== 2'b00) begin n_err++; $display("FAIL reset_hazard: got %b want 00", {HazardA, HazardB}); end
    Reset_n = 1'b1; DrainEn = 1'b0;
    tick();
  endtask

  task automatic test_fill_full();
    DrainEn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      InValid = 1'b1; InAddr = 4'(i); InData = 16'(16'h0010 + i);
      #1 tick();
    end
    #1;
    n_cmp++; if (Count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", Count); end
    n_cmp++; if (InReady !== 1'b0) begin n_err++; $display("FAIL full_inready: got %b want 0", InReady); end
    InAddr = 4'd5; InData = 16'h0015;
    #1 tick();
    InValid = 1'b0;
    #1;
    n_cmp++; if (Count !== 3'd4) begin n_err++; $display("FAIL full_reject: got %0d want 4", Count); end
    DrainEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({Write, WriteAddr, DataIn} !== {1'b1, 4'(i + 1), 16'(16'h0011 + i)}) begin
        n_err++; $display("FAIL drain_%0d: got %b/%h/%h want 1/%h/%h", i, Write, WriteAddr, DataIn, 4'(i + 1), 16'(16'h0011 + i));
      end
      tick();
    end
    #1;
    n_cmp++; if ({Count, Write} !== 4'b0000) begin n_err++; $display("FAIL drain_empty: got count %0d write %b want 0/0", Count, Write); end
    DrainEn = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] heads [5];
    heads = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    DrainEn = 1'b0; InValid = 1'b1;
    InAddr = 4'd8; InData = 16'h0088; #1 tick();
    InAddr = 4'd9; InData = 16'h0099; #1 tick();
    DrainEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InAddr = 4'(10 + i); InData = 16'(16'h00A0 + i);
      #1;
      n_cmp++; if ({Write, WriteAddr} !== {1'b1, heads[i]}) begin n_err++; $display("FAIL simul_head_%0d: got %b/%h want 1/%h", i, Write, WriteAddr, heads[i]); end
      tick();
      #1;
      n_cmp++; if (Count !== 3'd2) begin n_err++; $display("FAIL simul_count_%0d: got %0d want 2", i, Count); end
    end
    InValid = 1'b0;
    for (int i = 3; i < 5; i++) begin
      #1;
      n_cmp++; if ({WriteAddr, DataIn} !== {heads[i], 16'(16'h00A0 + i - 2)}) begin n_err++; $display("FAIL simul_tail_%0d: got %h/%h want %h/%h", i, WriteAddr, DataIn, heads[i], 16'(16'h00A0 + i - 2)); end
      tick();
    end
    DrainEn = 1'b0;
  endtask

  task automatic test_same_reg();
    logic [15:0] exp_op;
    logic        exp_hz;
    DrainEn = 1'b0; InValid = 1'b1; InAddr = 4'd7;
    InData = 16'hAAAA; #1 tick();
    InData = 16'hBBBB; #1 tick();
    InValid = 1'b0; ReadAddrA = 4'd7; ReadDataA = 16'h0000; ReadAddrB = 4'd6; ReadDataB = 16'h5555;
`ifdef WB_BYPASS_EN
    exp_op = 16'hBBBB; exp_hz = 1'b0;
`else
    exp_op = 16'h0000; exp_hz = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      DrainEn = (i != 0);
      #1;
      n_cmp++; if ({OperandA, HazardA} !== {exp_op, exp_hz}) begin n_err++; $display("FAIL samereg_a_%0d: got %h/%b want %h/%b", i, OperandA, HazardA, exp_op, exp_hz); end
      if (i != 0) tick();
    end
    DrainEn = 1'b0;
    #1;
    n_cmp++; if ({OperandA, HazardA, OperandB, HazardB} !== {16'h0000, 1'b0, 16'h5555, 1'b0}) begin
      n_err++; $display("FAIL samereg_done: got %h/%b %h/%b want 0000/0 5555/0", OperandA, HazardA, OperandB, HazardB);
    end
    n_cmp++; if (rf_dut[7] !== 16'hBBBB) begin n_err++; $display("FAIL samereg_r7: got %h want bbbb", rf_dut[7]); end
  endtask

  task automatic test_flush();
    DrainEn = 1'b0; InValid = 1'b1;
    for (int i = 0; i < 3; i++) begin InAddr = 4'(i + 1); InData = 16'(16'h0300 + i); #1 tick(); end
    #1;
    n_cmp++; if (Count !== 3'd3) begin n_err++; $display("FAIL flush_pre: got %0d want 3", Count); end
    Flush = 1'b1; InAddr = 4'd9; InData = 16'h0909; ReadAddrA = 4'd1; ReadAddrB = 4'd9;
    #1 tick();
    Flush = 1'b0; InValid = 1'b0; DrainEn = 1'b1;
    #1;
    n_cmp++; if ({Count, Write, HazardA, HazardB} !== 6'b000000) begin
      n_err++; $display("FAIL flush_post: got count %0d write %b hz %b%b want 0/0/00", Count, Write, HazardA, HazardB);
    end
    DrainEn = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    DrainEn = 1'b0; InValid = 1'b1;
    InAddr = 4'd2; InData = 16'h2222; #1 tick();
    InAddr = 4'd3; InData = 16'h3333; #1 tick();
    InValid = 1'b0; DrainEn = 1'b1; Reset_n = 1'b0;
    #1 tick();
    Reset_n = 1'b1;
    #1;
    n_cmp++; if (Count !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", Count); end
    pulses = wr_pulses;
    repeat (3) tick();
    n_cmp++; if (wr_pulses !== pulses) begin n_err++; $display("FAIL rstmid_nowrite: got %0d pulses want 0", wr_pulses - pulses); end
    DrainEn = 1'b0;
  endtask

  task automatic test_random();
    logic [58:0] got, want;
    logic [15:0] opa, opb;
    logic        hza, hzb;
    Reset_n = 1'b0; tick(); Reset_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      Reset_n   = ($urandom_range(0, 59) != 0);
      Flush     = ($urandom_range(0, 24) == 0);
      InValid   = ($urandom_range(0, 9) < 6);
      DrainEn   = ($urandom_range(0, 9) < 5);
      InAddr    = 4'($urandom_range(0, 4));
      InData    = 16'($urandom);
      ReadAddrA = 4'($urandom_range(0, 4));
      ReadAddrB = 4'($urandom_range(0, 4));
      ReadDataA = 16'($urandom);
      ReadDataB = 16'($urandom);
      #1;
`ifdef WB_BYPASS_EN
      opa = newest(ReadAddrA, ReadDataA); opb = newest(ReadAddrB, ReadDataB); hza = 1'b0; hzb = 1'b0;
`else
      opa = ReadDataA; opb = ReadDataB; hza = any_match(ReadAddrA); hzb = any_match(ReadAddrB);
`endif
      want = {q.size() != 4, (q.size() != 0) && DrainEn,
              (q.size() != 0) ? q[0].a : 4'h0, (q.size() != 0) ? q[0].d : 16'h0,
              3'(q.size()), opa, opb, hza, hzb};
      got  = {InReady, Write, WriteAddr, DataIn, Count, OperandA, OperandB, HazardA, HazardB};
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL random_%0d: got %h want %h", c, got, want); end
      tick();
    end
    Flush = 1'b0; InValid = 1'b0; DrainEn = 1'b0; Reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_full();
    test_simultaneous();
    test_same_reg();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
